// File: rtl/add_sub_pkg.sv
// Shared widths, opcodes and stored-entry layout for the add/sub result stage.
package add_sub_pkg;

    localparam int unsigned DATA_W  = 4;
    localparam int unsigned ENTRY_W = DATA_W + 3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Entry layout: {ovf, neg, zero, result}
    localparam int unsigned ZERO_BIT = DATA_W;
    localparam int unsigned NEG_BIT  = DATA_W + 1;
    localparam int unsigned OVF_BIT  = DATA_W + 2;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [DATA_W-1:0] r,
                                                      input logic zero,
                                                      input logic neg,
                                                      input logic ovf);
        return {ovf, neg, zero, r};
    endfunction

endpackage

// File: rtl/add_sub_4bit.sv
// Combinational 4-bit add/subtract core with zero, negative and signed-overflow flags.
module add_sub_4bit
    import add_sub_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_sel,
    output logic [DATA_W-1:0] o_r,
    output logic              o_zero,
    output logic              o_neg,
    output logic              o_ovf
);

    logic [DATA_W-1:0] w_b_eff;
    logic [DATA_W-1:0] w_r;

    always_comb begin
        w_b_eff = (i_sel == OP_ADD) ? i_b : ~i_b;
        // Subtract as a + ~b + 1; the carry-in is the select bit itself.
        w_r     = i_a + w_b_eff + {{(DATA_W-1){1'b0}}, i_sel};
    end

    always_comb begin
        o_r    = w_r;
        o_zero = (w_r == '0);
        o_neg  = w_r[DATA_W-1];
        if (i_sel == OP_SUB) begin
            o_ovf = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (w_r[DATA_W-1] != i_a[DATA_W-1]);
        end else begin
            o_ovf = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (w_r[DATA_W-1] != i_a[DATA_W-1]);
        end
    end

endmodule

// File: rtl/add_sub_result_stage.sv
// Valid/ready wrapper around add_sub_4bit: results plus flags are queued in a small FIFO.
module add_sub_result_stage
    import add_sub_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_select,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_neg,
    output logic              out_ovf,
    output logic              ovf_seen,
    input  logic              clr_sticky,
    output logic [CNT_W-1:0]  op_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               r_ovf_seen;
    logic [CNT_W-1:0]   r_op_count;

    logic [DATA_W-1:0]  w_r;
    logic               w_zero;
    logic               w_neg;
    logic               w_ovf;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_head;

    add_sub_4bit u_core (
        .i_a    (in_a),
        .i_b    (in_b),
        .i_sel  (in_select),
        .o_r    (w_r),
        .o_zero (w_zero),
        .o_neg  (w_neg),
        .o_ovf  (w_ovf)
    );

    always_comb begin
        in_ready   = (r_count != FULL_CNT);
        out_valid  = (r_count != '0);
        w_push     = in_valid && in_ready;
        w_pop      = out_valid && out_ready;
        w_head     = r_mem[r_rd_ptr];
        out_result = w_head[DATA_W-1:0];
        out_zero   = w_head[ZERO_BIT];
        out_neg    = w_head[NEG_BIT];
        out_ovf    = w_head[OVF_BIT];
        ovf_seen   = r_ovf_seen;
        op_count   = r_op_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovf_seen <= 1'b0;
            r_op_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= pack_entry(w_r, w_zero, w_neg, w_ovf);
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                if (r_op_count != '1) begin
                    r_op_count <= r_op_count + CNT_W'(1);
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            // A popped overflow wins over a same-cycle clear.
            if (w_pop && w_head[OVF_BIT]) begin
                r_ovf_seen <= 1'b1;
            end else if (clr_sticky) begin
                r_ovf_seen <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_add_sub_result_stage.sv
// Self-checking bench: queue-based reference model compared every cycle, plus literal checks.
module tb_add_sub_result_stage;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_a = '0;
    logic [3:0]       in_b = '0;
    logic             in_select = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [3:0]       out_result;
    logic             out_zero;
    logic             out_neg;
    logic             out_ovf;
    logic             ovf_seen;
    logic             clr_sticky = 1'b0;
    logic [CNT_W-1:0] op_count;

    int n_vec = 0;
    int n_err = 0;

    add_sub_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_select  (in_select),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_ovf    (out_ovf),
        .ovf_seen   (ovf_seen),
        .clr_sticky (clr_sticky),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference result: {ovf, neg, zero, r} from signed integer arithmetic.
    function automatic logic [6:0] model_entry(input logic [3:0] a, input logic [3:0] b,
                                               input logic sel);
        int sa, sb, full;
        logic [3:0] r;
        logic ovf;
        sa   = (a >= 8) ? int'(a) - 16 : int'(a);
        sb   = (b >= 8) ? int'(b) - 16 : int'(b);
        full = sel ? sa - sb : sa + sb;
        r    = 4'(full);
        ovf  = (full > 7) || (full < -8);
        return {ovf, r[3], (r == 4'd0), r};
    endfunction

    logic [6:0] m_q[$];
    int         m_opc = 0;
    logic       m_ovf = 1'b0;
    logic       m_fresh = 1'b1;
    logic       m_live = 1'b0;

    always @(negedge clk) begin
        logic [6:0] e;
        logic push, pop;
        if (m_live) begin
            chk("in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
            chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                chk("head", 32'({out_ovf, out_neg, out_zero, out_result}), 32'(m_q[0]));
            end else if (m_fresh) begin
                chk("head_cleared", 32'({out_ovf, out_neg, out_zero, out_result}), 32'd0);
            end
            chk("op_count", 32'(op_count), 32'(m_opc));
            chk("ovf_seen", 32'(ovf_seen), 32'(m_ovf));
        end
        if (rst) begin
            m_q.delete();
            m_opc   = 0;
            m_ovf   = 1'b0;
            m_fresh = 1'b1;
            m_live  = 1'b1;
        end else if (m_live) begin
            push = in_valid && (m_q.size() != DEPTH);
            pop  = out_ready && (m_q.size() != 0);
            if (pop) begin
                e = m_q.pop_front();
                if (m_opc != 255) m_opc++;
                if (e[6]) m_ovf = 1'b1;
                else if (clr_sticky) m_ovf = 1'b0;
            end else if (clr_sticky) begin
                m_ovf = 1'b0;
            end
            if (push) begin
                m_q.push_back(model_entry(in_a, in_b, in_select));
                m_fresh = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [3:0] a, input logic [3:0] b, input logic sel);
        in_a = a; in_b = b; in_select = sel; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        step();
        chk("lit_reset_valid", 32'(out_valid), 32'd0);
        chk("lit_reset_ready", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        push_one(4'b1101, 4'b0001, 1'b0);
        chk("lit_add_result", 32'(out_result), 32'hE);
        chk("lit_add_flags", 32'({out_ovf, out_neg, out_zero}), 32'b010);
        step();
        chk("lit_opc1", 32'(op_count), 32'd1);

        push_one(4'b1101, 4'b0001, 1'b1);
        chk("lit_sub_result", 32'(out_result), 32'hC);
        chk("lit_sub_flags", 32'({out_ovf, out_neg, out_zero}), 32'b010);
        step();

        push_one(4'b0111, 4'b0001, 1'b0);
        chk("lit_ovf_result", 32'(out_result), 32'h8);
        chk("lit_ovf_flag", 32'(out_ovf), 32'd1);
        step();
        chk("lit_ovf_seen", 32'(ovf_seen), 32'd1);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        chk("lit_ovf_clr", 32'(ovf_seen), 32'd0);

        push_one(4'b0011, 4'b0011, 1'b1);
        chk("lit_zero", 32'({out_zero, out_result}), 32'h10);
        step();

        // Fill to full with backpressure, then a fifth request that must be ignored.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(4'(i + 1), 4'd1, 1'b0);
        chk("lit_full", 32'(in_ready), 32'd0);
        push_one(4'd9, 4'd9, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("lit_drain", 32'(out_result), 32'(i + 2));
            step();
        end
        for (int i = 0; i < 3; i++) push_one(4'(i), 4'd5, 1'b1);
        step();

        // Simultaneous push and pop at count 2.
        out_ready = 1'b0;
        push_one(4'd1, 4'd2, 1'b0);
        push_one(4'd3, 4'd4, 1'b0);
        in_a = 4'd6; in_b = 4'd1; in_select = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lit_pushpop_head", 32'(out_result), 32'd7);
        for (int i = 0; i < 5; i++) step();

        // Reset with three entries held.
        out_ready = 1'b0;
        push_one(4'd7, 4'd7, 1'b0);
        push_one(4'd2, 4'd2, 1'b0);
        push_one(4'd4, 4'd4, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("lit_rst_valid", 32'(out_valid), 32'd0);
        chk("lit_rst_ready", 32'(in_ready), 32'd1);
        chk("lit_rst_opc", 32'(op_count), 32'd0);
        chk("lit_rst_ovf", 32'(ovf_seen), 32'd0);

        // Random traffic; enough pops to drive op_count into saturation.
        for (int i = 0; i < 1500; i++) begin
            in_valid   = ($urandom_range(0, 9) < 6);
            out_ready  = ($urandom_range(0, 9) < 5);
            clr_sticky = ($urandom_range(0, 19) == 0);
            in_a       = 4'($urandom);
            in_b       = 4'($urandom);
            in_select  = 1'($urandom);
            step();
        end
        in_valid = 1'b0; clr_sticky = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("lit_sat", 32'(op_count), 32'hFF);
        push_one(4'd1, 4'd1, 1'b0);
        step();
        chk("lit_sat_hold", 32'(op_count), 32'hFF);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
